// File: rtl/approx_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : approx_acc_pkg
// Description : Shared types, constants and the accumulate/carry helper for
//               the approximate-product accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package approx_acc_pkg;

    localparam int PROD_W    = 16;
    localparam int ACC_MAX_W = 32;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    typedef struct packed {
        logic [ACC_MAX_W-1:0] sum;
        logic                 carry;
    } acc_add_t;

    // acc is expected to be below 2^acc_w; the carry is the bit at position acc_w.
    function automatic acc_add_t acc_add_f(
        input logic [ACC_MAX_W-1:0] acc,
        input logic [PROD_W-1:0]    prod,
        input logic                 sat,
        input logic [5:0]           acc_w
    );
        logic [ACC_MAX_W:0] full;
        logic [ACC_MAX_W:0] lim;
        acc_add_t           res;
        full      = {1'b0, acc} + {{(ACC_MAX_W + 1 - PROD_W){1'b0}}, prod};
        lim       = ({{ACC_MAX_W{1'b0}}, 1'b1} << acc_w) - {{ACC_MAX_W{1'b0}}, 1'b1};
        res.carry = |(full & ~lim);
        full      = full & lim;
        res.sum   = (sat && res.carry) ? lim[ACC_MAX_W-1:0] : full[ACC_MAX_W-1:0];
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/approx_prod_stage.sv
`default_nettype none
// ============================================================================
// Module      : approx_prod_stage
// Description : Registered product stage with valid/ready handshake feeding
//               the accumulator state machine.
// Revision    : 1.0 - initial release
// ============================================================================
module approx_prod_stage
    import approx_acc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              accum,
    input  logic              consume,
    output logic [PROD_W-1:0] p_q,
    output logic              p_last,
    output logic              p_valid
);

    logic [PROD_W-1:0] prod_q, prod_d;
    logic              last_q, last_d;
    logic              valid_q, valid_d;
    logic              load;

    // While accumulating the held term drains every cycle, so a new one may enter.
    assign in_ready = !valid_q | accum;
    assign load     = in_valid & in_ready;

    always_comb begin
        prod_d  = prod_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (load) begin
            prod_d  = in_prod;
            last_d  = in_last;
            valid_d = 1'b1;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            prod_q  <= prod_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign p_q     = prod_q;
    assign p_last  = last_q;
    assign p_valid = valid_q;

endmodule
`default_nettype wire

// File: rtl/approx_prod_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : approx_prod_accumulator
// Description : Streams 16-bit products into a per-vector sum and emits one
//               result per vector. Define APPROX_ACC_SAT_EN to saturate the
//               sum instead of wrapping on overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module approx_prod_accumulator
    import approx_acc_pkg::*;
#(
    parameter  int ACC_W   = 24,
    parameter  int MAX_LEN = 256,
    localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_len,
    output logic              out_ovf,
    output logic              out_trunc
);

`ifdef APPROX_ACC_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    acc_state_t           state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 trunc_q, trunc_d;

    logic [PROD_W-1:0]    p_q;
    logic                 p_last;
    logic                 p_valid;
    logic                 accum;
    logic                 consume;
    logic [ACC_MAX_W-1:0] acc_ext;
    acc_add_t             add_r;
    logic                 unused_sum;

    assign accum   = (state_q == ACCUM);
    assign consume = accum & p_valid;

    approx_prod_stage u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_prod  (in_prod),
        .in_last  (in_last),
        .in_ready (in_ready),
        .accum    (accum),
        .consume  (consume),
        .p_q      (p_q),
        .p_last   (p_last),
        .p_valid  (p_valid)
    );

    always_comb begin
        acc_ext              = '0;
        acc_ext[ACC_W-1:0]   = acc_q;
        add_r                = acc_add_f(acc_ext, p_q, SAT_EN, 6'(ACC_W));
    end

    assign unused_sum = ^add_r.sum;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        trunc_d   = trunc_q;
        out_valid = 1'b0;
        case (state_q)
            ACCUM: begin
                if (p_valid) begin
                    acc_d = add_r.sum[ACC_W-1:0];
                    cnt_d = cnt_q + CNT_W'(1);
                    ovf_d = ovf_q | add_r.carry;
                    // An explicit last on the limit term is a normal close, not a truncation.
                    if (p_last) begin
                        state_d = HOLD;
                    end else if (cnt_q == CNT_W'(MAX_LEN - 1)) begin
                        state_d = HOLD;
                        trunc_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    trunc_d = 1'b0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            trunc_q <= trunc_d;
        end
    end

    assign out_acc   = acc_q;
    assign out_len   = cnt_q;
    assign out_ovf   = ovf_q;
    assign out_trunc = trunc_q;

endmodule
`default_nettype wire

// File: tb/tb_approx_prod_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_approx_prod_accumulator
// Description : Directed self-checking bench for approx_prod_accumulator
//               (ACC_W = 17, MAX_LEN = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_approx_prod_accumulator;

    localparam int ACC_W   = 17;
    localparam int MAX_LEN = 4;
    localparam int CNT_W   = 3;

`ifdef APPROX_ACC_SAT_EN
    localparam logic [31:0] EXP_OVF_SUM = 32'h1FFFF;
`else
    localparam logic [31:0] EXP_OVF_SUM = 32'h0FFFD;
`endif

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic [15:0]      in_prod   = '0;
    logic             in_last   = 1'b0;
    logic             out_ready = 1'b1;
    logic             in_ready;
    logic             out_valid;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_len;
    logic             out_ovf;
    logic             out_trunc;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] acc;
        logic [2:0]  len;
        logic        ovf;
        logic        trunc;
    } res_t;

    res_t res_q[$];

    approx_prod_accumulator #(
        .ACC_W   (ACC_W),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_len   (out_len),
        .out_ovf   (out_ovf),
        .out_trunc (out_trunc)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid && out_ready)
            res_q.push_back('{32'(out_acc), out_len, out_ovf, out_trunc});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] p, input logic l);
        int   t;
        logic hs;
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = l;
        t        = 0;
        do begin
            hs = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!hs && t < 40);
        if (!hs) chk("push_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_res(input string tag, input logic [31:0] acc, input logic [2:0] len,
                            input logic ovf, input logic trunc);
        int   t;
        res_t r;
        t = 0;
        while (res_q.size() == 0 && t < 60) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (res_q.size() == 0) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            r = res_q.pop_front();
            chk({tag, "_acc"},   r.acc,         acc);
            chk({tag, "_len"},   32'(r.len),    32'(len));
            chk({tag, "_ovf"},   32'(r.ovf),    32'(ovf));
            chk({tag, "_trunc"}, 32'(r.trunc),  32'(trunc));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_acc",   32'(out_acc),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic vector, latency and single-cycle result.
        push(16'd100, 1'b0);
        push(16'd200, 1'b0);
        push(16'd300, 1'b1);
        chk("t1_lat_edge1", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("t1_lat_edge2", 32'(out_valid), 32'd1);
        chk("t1_acc_live",  32'(out_acc),   32'd600);
        @(posedge clk);
        #1;
        chk("t1_one_cycle", 32'(out_valid), 32'd0);
        wait_res("t1", 32'd600, 3'd3, 1'b0, 1'b0);

        // Back-pressure on the result while the next vector streams in.
        out_ready = 1'b0;
        push(16'd100, 1'b0);
        push(16'd200, 1'b0);
        push(16'd300, 1'b1);
        push(16'd5,   1'b0);
        fork
            push(16'd6, 1'b1);
            begin
                chk("t2_in_ready_low", 32'(in_ready), 32'd0);
                for (int k = 0; k < 4; k++) begin
                    chk("t2_hold_valid", 32'(out_valid), 32'd1);
                    chk("t2_hold_acc",   32'(out_acc),   32'd600);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_res("t2a", 32'd600, 3'd3, 1'b0, 1'b0);
        wait_res("t2b", 32'd11,  3'd2, 1'b0, 1'b0);

        // Overflow: wrap or saturate depending on build.
        push(16'hFFFF, 1'b0);
        push(16'hFFFF, 1'b0);
        push(16'hFFFF, 1'b1);
        wait_res("t3", EXP_OVF_SUM, 3'd3, 1'b1, 1'b0);

        // Length limit closes the vector; the remainder forms a new one.
        for (int k = 0; k < 6; k++) push(16'd1, (k == 5));
        wait_res("t4a", 32'd4, 3'd4, 1'b0, 1'b1);
        wait_res("t4b", 32'd2, 3'd2, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) push(16'd1, (k == 3));
        wait_res("t4c", 32'd4, 3'd4, 1'b0, 1'b0);

        // Asynchronous reset mid-vector.
        push(16'd10, 1'b0);
        push(16'd20, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_acc",   32'(out_acc),   32'd0);
        chk("t5_rst_len",   32'(out_len),   32'd0);
        chk("t5_rst_ovf",   32'(out_ovf),   32'd0);
        chk("t5_rst_trunc", 32'(out_trunc), 32'd0);
        chk("t5_rst_ready", 32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_no_stale", 32'(res_q.size()), 32'd0);
        push(16'd7, 1'b1);
        wait_res("t5", 32'd7, 3'd1, 1'b0, 1'b0);

        // Single-term vectors separated by 0..3 bubble cycles.
        for (int i = 0; i < 4; i++) begin
            push(16'd9, 1'b1);
            repeat (i) begin
                @(posedge clk);
                #1;
            end
            push(16'd4, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            wait_res("t6a", 32'd9, 3'd1, 1'b0, 1'b0);
            wait_res("t6b", 32'd4, 3'd1, 1'b0, 1'b0);
        end
        repeat (6) @(posedge clk);
        #1;
        chk("t6_no_extra", 32'(res_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
